// File: rtl/clk_rst_gen.sv
// clk_rst_gen
// Divides a reference clock into a programmable-period, programmable-duty
// clock and produces a synchronously released, delayed active-low reset.
// Every output comes straight from a flop, so none of them can glitch.
module clk_rst_gen #(
  parameter int PERIOD = 10,   // generated period in reference cycles (>= 2)
  parameter int DUTY   = 50,   // high time in percent (1..99)
  parameter int DELAY  = 996,  // extra cycles rst_n_out stays low after sync
  parameter int CNT_W  = 32    // width of the completed-period counter
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic             clk_out,
  output logic             rst_n_out,
  output logic [CNT_W-1:0] period_cnt
);

  // Reject parameter sets that cannot produce a sensible clock.
  if (PERIOD < 2) begin : g_bad_period
    $error("clk_rst_gen: PERIOD must be >= 2");
  end
  if ((DUTY < 1) || (DUTY > 99)) begin : g_bad_duty
    $error("clk_rst_gen: DUTY must be in 1..99");
  end
  if (DELAY < 0) begin : g_bad_delay
    $error("clk_rst_gen: DELAY must be >= 0");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("clk_rst_gen: CNT_W must be >= 1");
  end

  // High time in reference cycles. The clamp guarantees that both phases
  // exist, even for extreme duty values on short periods.
  localparam int HIGH_RAW = (PERIOD * DUTY) / 100;
  localparam int HIGH     = (HIGH_RAW < 1)          ? 1 :
                            (HIGH_RAW > PERIOD - 1) ? PERIOD - 1 : HIGH_RAW;

  localparam int PH_W        = (PERIOD < 2) ? 1 : $clog2(PERIOD);
  localparam int DLY_W       = (DELAY < 1)  ? 1 : $clog2(DELAY + 1);
  localparam int SYNC_STAGES = 2;

  localparam logic [PH_W-1:0]  PHASE_LAST = PH_W'(PERIOD - 1);
  localparam logic [PH_W-1:0]  PHASE_HIGH = PH_W'(HIGH);
  localparam logic [DLY_W-1:0] DLY_MAX    = DLY_W'(DELAY);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [DLY_W-1:0]       r_dly_cnt;
  logic                   r_rst_n_out;
  logic [PH_W-1:0]        r_phase;
  logic                   r_clk_out;
  logic [CNT_W-1:0]       r_period_cnt;

  logic                   w_srst_n;
  logic                   w_dly_done;
  logic [PH_W-1:0]        w_phase_next;
  logic                   w_clk_next;
  logic                   w_rise;

  // Reset synchronizer: asserts asynchronously, releases after two edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign w_srst_n   = r_sync[SYNC_STAGES-1];
  assign w_dly_done = (r_dly_cnt == DLY_MAX);

  // Delay counter: runs once the synchronized reset is released, then parks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dly_cnt <= '0;
    end else if (w_srst_n && !w_dly_done) begin
      r_dly_cnt <= r_dly_cnt + DLY_W'(1);
    end
  end

  // Delayed reset output: set once the delay has elapsed, sticky until rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_n_out <= 1'b0;
    end else if (w_srst_n && w_dly_done) begin
      r_rst_n_out <= 1'b1;
    end
  end

  // Next phase / clock level. Disabling snaps the phase back to 0 so the
  // next enabled edge always opens a complete high phase.
  always_comb begin
    w_phase_next = r_phase;
    w_clk_next   = r_clk_out;
    if (w_srst_n) begin
      if (en) begin
        w_clk_next   = (r_phase < PHASE_HIGH);
        w_phase_next = (r_phase == PHASE_LAST) ? '0 : r_phase + PH_W'(1);
      end else begin
        w_clk_next   = 1'b0;
        w_phase_next = '0;
      end
    end
  end

  assign w_rise = w_clk_next & ~r_clk_out;

  // Phase counter and generated clock register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase   <= '0;
      r_clk_out <= 1'b0;
    end else begin
      r_phase   <= w_phase_next;
      r_clk_out <= w_clk_next;
    end
  end

  // Period counter: one count per clk_out rising transition, free-wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_period_cnt <= '0;
    end else if (w_rise) begin
      r_period_cnt <= r_period_cnt + CNT_W'(1);
    end
  end

  assign clk_out    = r_clk_out;
  assign rst_n_out  = r_rst_n_out;
  assign period_cnt = r_period_cnt;

endmodule

// File: tb/tb_clk_rst_gen.sv
// tb_clk_rst_gen
// Runs five differently parameterised clk_rst_gen instances side by side on
// one reference clock and compares them against an edge-index model.
module tb_clk_rst_gen;

  localparam int N = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic en    = 1'b0;

  logic        d_clk [N];
  logic        d_rst [N];
  logic [31:0] d_cnt [N];

  logic [31:0] cnt0;
  logic [3:0]  cnt1;
  logic [7:0]  cnt2;
  logic [3:0]  cnt3;
  logic [15:0] cnt4;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: k = rising edges since rst_n release.
  int          k;
  int          run_start [N];
  logic        m_clk [N];
  logic        m_rst [N];
  logic [31:0] m_cnt [N];

  always #5 clk = ~clk;

  clk_rst_gen #(.PERIOD(10), .DUTY(50), .DELAY(996), .CNT_W(32)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .en(en),
    .clk_out(d_clk[0]), .rst_n_out(d_rst[0]), .period_cnt(cnt0));
  clk_rst_gen #(.PERIOD(10), .DUTY(30), .DELAY(0), .CNT_W(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en),
    .clk_out(d_clk[1]), .rst_n_out(d_rst[1]), .period_cnt(cnt1));
  clk_rst_gen #(.PERIOD(10), .DUTY(1), .DELAY(5), .CNT_W(8)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .en(en),
    .clk_out(d_clk[2]), .rst_n_out(d_rst[2]), .period_cnt(cnt2));
  clk_rst_gen #(.PERIOD(10), .DUTY(99), .DELAY(0), .CNT_W(4)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .en(en),
    .clk_out(d_clk[3]), .rst_n_out(d_rst[3]), .period_cnt(cnt3));
  clk_rst_gen #(.PERIOD(7), .DUTY(60), .DELAY(3), .CNT_W(16)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .en(en),
    .clk_out(d_clk[4]), .rst_n_out(d_rst[4]), .period_cnt(cnt4));

  assign d_cnt[0] = cnt0;
  assign d_cnt[1] = {28'd0, cnt1};
  assign d_cnt[2] = {24'd0, cnt2};
  assign d_cnt[3] = {28'd0, cnt3};
  assign d_cnt[4] = {16'd0, cnt4};

  // Per-instance parameters, mirrored from the instantiations above.
  function automatic int mp(int i);
    return (i == 4) ? 7 : 10;
  endfunction
  function automatic int md(int i);
    case (i)
      0: return 50;
      1: return 30;
      2: return 1;
      3: return 99;
      default: return 60;
    endcase
  endfunction
  function automatic int mdly(int i);
    case (i)
      0: return 996;
      2: return 5;
      4: return 3;
      default: return 0;
    endcase
  endfunction
  function automatic int mw(int i);
    case (i)
      0: return 32;
      2: return 8;
      4: return 16;
      default: return 4;
    endcase
  endfunction
  function automatic int mh(int i);
    int h;
    h = (mp(i) * md(i)) / 100;
    if (h < 1) h = 1;
    if (h > mp(i) - 1) h = mp(i) - 1;
    return h;
  endfunction
  function automatic logic [31:0] mmask(int i);
    if (mw(i) >= 32) return 32'hFFFF_FFFF;
    return (32'd1 << mw(i)) - 32'd1;
  endfunction

  task automatic model_reset();
    k = 0;
    for (int i = 0; i < N; i++) begin
      run_start[i] = -1;
      m_clk[i]     = 1'b0;
      m_rst[i]     = 1'b0;
      m_cnt[i]     = 32'd0;
    end
  endtask

  // Expected outputs after a rising edge. An enabled run that starts at edge
  // s produces clk high whenever (edge - s) mod PERIOD < HIGH.
  task automatic model_edge();
    logic nc;
    if (rst_n) k++;
    for (int i = 0; i < N; i++) begin
      nc = 1'b0;
      if (rst_n && k >= 3) begin
        if (en) begin
          if (run_start[i] < 0) run_start[i] = k;
          nc = (((k - run_start[i]) % mp(i)) < mh(i));
        end else begin
          run_start[i] = -1;
        end
      end
      if (nc && !m_clk[i]) m_cnt[i] = (m_cnt[i] + 32'd1) & mmask(i);
      m_clk[i] = nc;
      m_rst[i] = rst_n && (k >= 3 + mdly(i));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    rst_n = 1'b0;
    en    = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        n_checks++;
        if (d_clk[i] !== 1'b0) $display("FAIL reset_clk_out[%0d]: got %b expected 0", i, d_clk[i]);
        else n_pass++;
        n_checks++;
        if (d_rst[i] !== 1'b0) $display("FAIL reset_rst_n_out[%0d]: got %b expected 0", i, d_rst[i]);
        else n_pass++;
        n_checks++;
        if (d_cnt[i] !== 32'd0) $display("FAIL reset_period_cnt[%0d]: got %0d expected 0", i, d_cnt[i]);
        else n_pass++;
      end
    end
    rst_n = 1'b1;
    $display("test_reset: done, checks=%0d", n_checks);
  endtask

  task automatic test_first_pulse();
    en = 1'b1;
    for (int c = 0; c < 95; c++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        n_checks++;
        if (d_clk[i] !== m_clk[i]) $display("FAIL first_clk_out[%0d] edge %0d: got %b expected %b", i, k, d_clk[i], m_clk[i]);
        else n_pass++;
        n_checks++;
        if (d_rst[i] !== m_rst[i]) $display("FAIL first_rst_n_out[%0d] edge %0d: got %b expected %b", i, k, d_rst[i], m_rst[i]);
        else n_pass++;
        n_checks++;
        if (d_cnt[i] !== m_cnt[i]) $display("FAIL first_period_cnt[%0d] edge %0d: got %0d expected %0d", i, k, d_cnt[i], m_cnt[i]);
        else n_pass++;
        if (k == 2 + mdly(i)) begin
          n_checks++;
          if (d_rst[i] !== 1'b0) $display("FAIL delay_low[%0d] edge %0d: got %b expected 0", i, k, d_rst[i]);
          else n_pass++;
        end
        if (k == 3 + mdly(i)) begin
          n_checks++;
          if (d_rst[i] !== 1'b1) $display("FAIL delay_high[%0d] edge %0d: got %b expected 1", i, k, d_rst[i]);
          else n_pass++;
        end
      end
      if (k == 2) begin
        n_checks++;
        if (d_clk[0] !== 1'b0) $display("FAIL edge2_clk_out: got %b expected 0", d_clk[0]);
        else n_pass++;
      end
      if (k == 3) begin
        n_checks++;
        if (d_clk[0] !== 1'b1 || d_cnt[0] !== 32'd1)
          $display("FAIL edge3_first_pulse: got clk=%b cnt=%0d expected clk=1 cnt=1", d_clk[0], d_cnt[0]);
        else n_pass++;
      end
      if (k == 93) begin
        n_checks++;
        if (d_cnt[0] !== 32'd10) $display("FAIL ten_periods_cnt: got %0d expected 10", d_cnt[0]);
        else n_pass++;
      end
    end
    $display("test_first_pulse: done at edge %0d, checks=%0d", k, n_checks);
  endtask

  task automatic test_en_gap();
    logic [31:0] saved;
    bit          found = 1'b0;
    en = 1'b1;
    // Wait until instance 0 has been high for two edges (mid high phase).
    for (int c = 0; c < 20 && !found; c++) begin
      tick();
      n_checks++;
      if (d_clk[0] !== m_clk[0]) $display("FAIL gap_wait_clk_out edge %0d: got %b expected %b", k, d_clk[0], m_clk[0]);
      else n_pass++;
      if (run_start[0] >= 0 && ((k - run_start[0]) % 10) == 1) found = 1'b1;
    end
    n_checks++;
    if (!found) $display("FAIL gap_wait_timeout: got no mid-high point expected one within 20 edges");
    else n_pass++;
    saved = m_cnt[0];
    en = 1'b0;
    for (int c = 0; c < 17; c++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        n_checks++;
        if (d_clk[i] !== m_clk[i]) $display("FAIL gap_clk_out[%0d] edge %0d: got %b expected %b", i, k, d_clk[i], m_clk[i]);
        else n_pass++;
        n_checks++;
        if (d_cnt[i] !== m_cnt[i]) $display("FAIL gap_period_cnt[%0d] edge %0d: got %0d expected %0d", i, k, d_cnt[i], m_cnt[i]);
        else n_pass++;
      end
      n_checks++;
      if (d_clk[0] !== 1'b0 || d_cnt[0] !== saved)
        $display("FAIL gap_frozen edge %0d: got clk=%b cnt=%0d expected clk=0 cnt=%0d", k, d_clk[0], d_cnt[0], saved);
      else n_pass++;
    end
    en = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        n_checks++;
        if (d_clk[i] !== m_clk[i]) $display("FAIL reen_clk_out[%0d] edge %0d: got %b expected %b", i, k, d_clk[i], m_clk[i]);
        else n_pass++;
      end
      n_checks++;
      if (d_clk[0] !== (c < 5) || d_cnt[0] !== saved + 32'd1)
        $display("FAIL reen_pulse cycle %0d: got clk=%b cnt=%0d expected clk=%b cnt=%0d",
                 c, d_clk[0], d_cnt[0], (c < 5), saved + 32'd1);
      else n_pass++;
    end
    $display("test_en_gap: done at edge %0d, checks=%0d", k, n_checks);
  endtask

  task automatic test_wrap();
    logic [31:0] prev;
    en = 1'b1;
    for (int c = 0; c < 200; c++) begin
      prev = m_cnt[1];
      tick();
      for (int i = 0; i < N; i++) begin
        n_checks++;
        if (d_cnt[i] !== m_cnt[i]) $display("FAIL wrap_period_cnt[%0d] edge %0d: got %0d expected %0d", i, k, d_cnt[i], m_cnt[i]);
        else n_pass++;
      end
      if (prev == 32'd15 && m_cnt[1] == 32'd0) begin
        n_checks++;
        if (d_cnt[1] !== 32'd0) $display("FAIL wrap_15_to_0 edge %0d: got %0d expected 0", k, d_cnt[1]);
        else n_pass++;
      end
    end
    $display("test_wrap: done at edge %0d, checks=%0d", k, n_checks);
  endtask

  task automatic test_random_en();
    int hold = 0;
    for (int c = 0; c < 2000 && k < 1005; c++) begin
      if (hold == 0) begin
        en   = ($urandom_range(0, 3) != 0);
        hold = $urandom_range(1, 30);
      end
      hold--;
      tick();
      for (int i = 0; i < N; i++) begin
        n_checks++;
        if (d_clk[i] !== m_clk[i]) $display("FAIL rand_clk_out[%0d] edge %0d: got %b expected %b", i, k, d_clk[i], m_clk[i]);
        else n_pass++;
        n_checks++;
        if (d_rst[i] !== m_rst[i]) $display("FAIL rand_rst_n_out[%0d] edge %0d: got %b expected %b", i, k, d_rst[i], m_rst[i]);
        else n_pass++;
        n_checks++;
        if (d_cnt[i] !== m_cnt[i]) $display("FAIL rand_period_cnt[%0d] edge %0d: got %0d expected %0d", i, k, d_cnt[i], m_cnt[i]);
        else n_pass++;
      end
      if (k == 998 || k == 999) begin
        n_checks++;
        if (d_rst[0] !== (k == 999)) $display("FAIL delay996 edge %0d: got %b expected %b", k, d_rst[0], (k == 999));
        else n_pass++;
      end
    end
    $display("test_random_en: done at edge %0d, checks=%0d", k, n_checks);
  endtask

  task automatic test_async_reset();
    int  hold  = 10;
    bit  found = 1'b0;
    en = 1'b1;
    for (int c = 0; c < 20 && !found; c++) begin
      tick();
      if (m_clk[0] && m_rst[0]) found = 1'b1;
    end
    n_checks++;
    if (!found) $display("FAIL async_wait_timeout: got no high clk_out expected one within 20 edges");
    else n_pass++;
    // Pulse rst_n between edges and look before any further edge arrives.
    #1 rst_n = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (d_clk[i] !== 1'b0 || d_rst[i] !== 1'b0 || d_cnt[i] !== 32'd0)
        $display("FAIL async_clear[%0d]: got clk=%b rst=%b cnt=%0d expected 0/0/0", i, d_clk[i], d_rst[i], d_cnt[i]);
      else n_pass++;
    end
    model_reset();
    rst_n = 1'b1;
    for (int c = 0; c < 1010; c++) begin
      if (hold == 0) begin
        en   = ($urandom_range(0, 3) != 0);
        hold = $urandom_range(1, 30);
      end
      hold--;
      tick();
      for (int i = 0; i < N; i++) begin
        n_checks++;
        if (d_clk[i] !== m_clk[i]) $display("FAIL rerun_clk_out[%0d] edge %0d: got %b expected %b", i, k, d_clk[i], m_clk[i]);
        else n_pass++;
        n_checks++;
        if (d_rst[i] !== m_rst[i]) $display("FAIL rerun_rst_n_out[%0d] edge %0d: got %b expected %b", i, k, d_rst[i], m_rst[i]);
        else n_pass++;
        n_checks++;
        if (d_cnt[i] !== m_cnt[i]) $display("FAIL rerun_period_cnt[%0d] edge %0d: got %0d expected %0d", i, k, d_cnt[i], m_cnt[i]);
        else n_pass++;
        if (k == 2 + mdly(i) || k == 3 + mdly(i)) begin
          n_checks++;
          if (d_rst[i] !== (k == 3 + mdly(i)))
            $display("FAIL rerun_delay[%0d] edge %0d: got %b expected %b", i, k, d_rst[i], (k == 3 + mdly(i)));
          else n_pass++;
        end
      end
      if (k == 3) begin
        n_checks++;
        if (d_clk[0] !== 1'b1 || d_cnt[0] !== 32'd1)
          $display("FAIL rerun_first_pulse: got clk=%b cnt=%0d expected clk=1 cnt=1", d_clk[0], d_cnt[0]);
        else n_pass++;
      end
    end
    $display("test_async_reset: done at edge %0d, checks=%0d", k, n_checks);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_first_pulse();
    test_en_gap();
    test_wrap();
    test_random_en();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
